// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the CPU memory stage and a
// byte-enabled, synchronous-read DMEM.
//
// One request is taken at a time over req_valid/req_ready. Misaligned or
// illegal requests are answered with resp_fault and never touch memory.
// Stores drive one ISSUE cycle with lane enables and replicated data.
// Loads issue the word address, capture mem_rdata one cycle later, and
// align and extend it into a held response.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_store, req_op    store flag and funct3 (B/H/W/BU/HU)
//   req_addr, req_wdata  byte address, right-justified store data
//   resp_valid/ready     response handshake
//   resp_rdata           extended load data (0 for stores and faults)
//   resp_fault           misaligned access or illegal op
//   mem_we, mem_addr     DMEM write enable and word address
//   mem_wdata_sel        DMEM byte-lane enables
//   mem_wdata, mem_rdata DMEM write data / read data (one-cycle latency)
module dmem_lsu #(
  parameter int ADDR_W = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wdata_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state_r;
  logic        store_r;
  logic [2:0]  op_r;
  logic [1:0]  off_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_fault_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [3:0]  mem_sel_r;
  logic [31:0] mem_wdata_r;

  logic [3:0]  sel_s;
  logic [31:0] wdata_s;
  logic        fault_s;
  logic        unused_s;

  // Misalignment and illegal-op check for an incoming request.
  function automatic logic is_fault(input logic st, input logic [2:0] op,
                                    input logic [1:0] a);
    logic f;
    case (op)
      3'b000:         f = 1'b0;
      3'b001, 3'b101: f = a[0];
      3'b010:         f = (a != 2'b00);
      3'b100:         f = 1'b0;
      default:        f = 1'b1;
    endcase
    // BU/HU have no store counterpart
    return f | (st & op[2]);
  endfunction

  // Select the addressed byte/half of a read word and sign/zero extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] op,
                                           input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(d >> {a, 3'b000});
    h = 16'(d >> {a[1], 4'b0000});
    case (op)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = d;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign fault_s  = is_fault(req_store, req_op, req_addr[1:0]);
  assign unused_s = ^req_addr[31:ADDR_W+2];

  // Store lane enables and lane-replicated data for the incoming request.
  always_comb begin
    sel_s   = 4'b0000;
    wdata_s = 32'h0000_0000;
    case (req_op)
      3'b000: begin
        sel_s   = 4'b0001 << req_addr[1:0];
        wdata_s = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        sel_s   = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        sel_s   = 4'b1111;
        wdata_s = req_wdata;
      end
      default: begin
        sel_s   = 4'b0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Control FSM with all registered outputs. The DMEM strobes are loaded
  // on the accept edge so they are visible for exactly the ISSUE cycle.
  // RESP spends its first cycle raising resp_valid, then waits for ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      store_r      <= 1'b0;
      op_r         <= 3'b000;
      off_r        <= 2'b00;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_fault_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_sel_r    <= 4'b0000;
      mem_wdata_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            store_r      <= req_store;
            op_r         <= req_op;
            off_r        <= req_addr[1:0];
            resp_rdata_r <= 32'h0000_0000;
            resp_fault_r <= fault_s;
            if (fault_s) begin
              state_r <= ST_RESP;
            end else begin
              state_r    <= ST_ISSUE;
              mem_addr_r <= {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
              if (req_store) begin
                mem_we_r    <= 1'b1;
                mem_sel_r   <= sel_s;
                mem_wdata_r <= wdata_s;
              end
            end
          end
        end
        ST_ISSUE: begin
          mem_we_r  <= 1'b0;
          mem_sel_r <= 4'b0000;
          state_r   <= store_r ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          resp_rdata_r <= load_ext(op_r, off_r, mem_rdata);
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          if (!resp_valid_r) begin
            resp_valid_r <= 1'b1;
          end else if (resp_ready) begin
            resp_valid_r <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          mem_we_r     <= 1'b0;
          mem_sel_r    <= 4'b0000;
        end
      endcase
    end
  end

  assign req_ready     = (state_r == ST_IDLE);
  assign resp_valid    = resp_valid_r;
  assign resp_rdata    = resp_rdata_r;
  assign resp_fault    = resp_fault_r;
  assign mem_we        = mem_we_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata_sel = mem_sel_r;
  assign mem_wdata     = mem_wdata_r;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wdata_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int we_snap;

  logic [31:0] mem [0:63];

  dmem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata_sel(mem_wdata_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte-enabled synchronous-read memory model; counts write strobes.
  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (mem_wdata_sel[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= mem[mem_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns 1ns after the accept edge.
  task automatic req(input logic st, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_op = op; req_addr = addr; req_wdata = wd;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // resp_valid must stay low until exactly lat edges after accept.
  task automatic wait_resp(input string tag, input int lat,
                           input logic exp_fault, input logic [31:0] exp_rdata);
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      if (i < lat) begin
        chk({tag, "_early"}, {31'd0, resp_valid}, 32'd0);
      end else begin
        chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_fault"}, {31'd0, resp_fault}, {31'd0, exp_fault});
        chk({tag, "_rdata"}, resp_rdata, exp_rdata);
      end
    end
  endtask

  task automatic ack(input string tag);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_ack_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_ack_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] e_addr,
                       input logic [3:0] e_sel, input logic [31:0] e_wd);
    req(1'b1, op, addr, wd);
    chk({tag, "_we"},    {31'd0, mem_we}, 32'd1);
    chk({tag, "_addr"},  mem_addr, e_addr);
    chk({tag, "_sel"},   {28'd0, mem_wdata_sel}, {28'd0, e_sel});
    chk({tag, "_wdata"}, mem_wdata, e_wd);
    wait_resp(tag, 2, 1'b0, 32'h0);
    ack(tag);
  endtask

  task automatic load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] exp);
    req(1'b0, op, addr, 32'h0);
    chk({tag, "_we"},  {31'd0, mem_we}, 32'd0);
    chk({tag, "_sel"}, {28'd0, mem_wdata_sel}, 32'd0);
    chk({tag, "_addr"}, mem_addr, {2'b00, addr[31:2]});
    wait_resp(tag, 3, 1'b0, exp);
    ack(tag);
  endtask

  task automatic fault(input string tag, input logic st, input logic [2:0] op,
                       input logic [31:0] addr);
    we_snap = we_cnt;
    req(st, op, addr, 32'hFFFF_FFFF);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    wait_resp(tag, 1, 1'b1, 32'h0);
    ack(tag);
    chk({tag, "_nowrite"}, we_cnt, we_snap);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_op = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    #12;
    chk("rst_req_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_we",     {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr",   mem_addr, 32'h0);
    chk("rst_sel",        {28'd0, mem_wdata_sel}, 32'd0);
    chk("rst_wdata",      mem_wdata, 32'h0);
    chk("rst_rdata",      resp_rdata, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Stores
    store("sw",  3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h4, 4'b1111, 32'hDEAD_BEEF);
    store("sb",  3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h4, 4'b1000, 32'hA5A5_A5A5);
    store("sh",  3'b001, 32'h0000_0012, 32'h0000_1234, 32'h4, 4'b1100, 32'h1234_1234);
    chk("mem4_merged", mem[4], 32'h1234_BEEF);
    store("sb0", 3'b000, 32'h0000_0011, 32'h0000_0077, 32'h4, 4'b0010, 32'h7777_7777);
    store("sw20", 3'b010, 32'h0000_0020, 32'h80FF_7F01, 32'h8, 4'b1111, 32'h80FF_7F01);

    // Loads from word 8 = 0x80FF7F01
    load("lb3",  3'b000, 32'h0000_0023, 32'hFFFF_FF80);
    load("lbu3", 3'b100, 32'h0000_0023, 32'h0000_0080);
    load("lb1",  3'b000, 32'h0000_0021, 32'h0000_007F);
    load("lh2",  3'b001, 32'h0000_0022, 32'hFFFF_80FF);
    load("lhu2", 3'b101, 32'h0000_0022, 32'h0000_80FF);
    load("lh0",  3'b001, 32'h0000_0020, 32'h0000_7F01);
    load("lw0",  3'b010, 32'h0000_0020, 32'h80FF_7F01);

    // Faults
    fault("f_lw2",  1'b0, 3'b010, 32'h0000_0002);
    fault("f_sh1",  1'b1, 3'b001, 32'h0000_0001);
    fault("f_op3",  1'b0, 3'b011, 32'h0000_0000);
    fault("f_st4",  1'b1, 3'b100, 32'h0000_0000);
    fault("f_lhu3", 1'b0, 3'b101, 32'h0000_0023);

    // Back-pressure: response held for 5 cycles with resp_ready low
    we_snap = we_cnt;
    req(1'b0, 3'b000, 32'h0000_0023, 32'h0);
    wait_resp("bp", 3, 1'b0, 32'hFFFF_FF80);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, 32'hFFFF_FF80);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_we",    {31'd0, mem_we}, 32'd0);
    end
    ack("bp");
    chk("bp_nowrite", we_cnt, we_snap);

    // Reset during the ISSUE cycle of a store
    we_snap = we_cnt;
    req(1'b1, 3'b010, 32'h0000_0030, 32'h1122_3344);
    chk("rs_we_issue", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_we_drop", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rs_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rs_req_ready",  {31'd0, req_ready}, 32'd1);
    chk("rs_nowrite",    we_cnt, we_snap);

    // Block still works after the reset
    load("post_lw", 3'b010, 32'h0000_0010, 32'h1234_77EF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that drives the byte-enabled, synchronous-read DMEM block from the CPU memory stage.
- Accepts one load or store request at a time over a valid/ready handshake.
- Generates DMEM word address, byte-lane write enables and lane-replicated write data.
- Captures DMEM read data one cycle after the read is issued, then aligns and sign- or zero-extends it into a held response.

Parameters:
ADDR_W, 17, DMEM word-address width; mem_addr carries the word index req_addr[ADDR_W+1:2], zero-extended to 32 bits.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_store  input  1  1 = store, 0 = load
req_op  input  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are load-only)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  response held
resp_ready  input  1  consumer takes the response
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_fault  output  1  misaligned access or illegal op; no memory access is performed
mem_we  output  1  DMEM write enable
mem_addr  output  32  DMEM word address
mem_wdata_sel  output  4  DMEM byte-lane enables
mem_wdata  output  32  DMEM write data
mem_rdata  input  32  DMEM read data, valid the cycle after the address is presented

Behaviour:
- All outputs are registered except req_ready, which is decoded from state.
- Reset values (asynchronous): state IDLE; mem_we 0; mem_wdata_sel 0; mem_addr 0; mem_wdata 0; resp_valid 0; resp_rdata 0; resp_fault 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid && req_ready at edge T.
  - Latch op, store flag and addr[1:0].
  - Fault conditions: H/HU with addr[0]=1; W with addr[1:0]!=0; op 011/110/111; store with op 1xx.
  - Fault: go to RESP with resp_fault=1 and resp_rdata=0. No mem_we is ever asserted.
  - Otherwise: go to ISSUE and drive mem_addr = {0, req_addr[ADDR_W+1:2]}.
- ISSUE, lasting exactly one cycle:
  - Store: mem_we=1, mem_wdata_sel and mem_wdata per the lane rules below. Next state RESP.
  - Load: mem_we=0, mem_wdata_sel=0. Next state WAIT.
- Store lane rules:
  - SB: sel = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: sel = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - SW: sel = 1111; wdata = wdata.
- WAIT:
  - Capture mem_rdata and extract by latched addr[1:0]:
    - B/BU: byte = rdata[8*a+7:8*a].
    - H/HU: half = rdata[16*a1+15:16*a1].
    - W: whole word.
  - B and H are sign-extended; BU and HU are zero-extended.
  - Next state RESP.
- Outside ISSUE, mem_we=0 and mem_wdata_sel=0. mem_addr and mem_wdata hold their last values.
- RESP:
  - resp_valid=1; resp_rdata and resp_fault held stable until resp_ready.
  - On resp_ready: resp_valid=0 at the next edge and the block returns to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Latency, measured from the accept edge T: fault response at T+1, store at T+2, load at T+3. With resp_ready held high, the minimum repeat interval is 3, 4 or 5 cycles respectively.
- Back-pressure: resp_ready low holds RESP indefinitely. DMEM sees no further activity.
- Reset mid-operation returns the block to IDLE and drops mem_we immediately.
  - A store whose ISSUE edge has not yet occurred is not written.
  - A pending response is discarded.
- Inputs other than req_valid are don't-care when no request is being accepted.

Test Plan:
- Reset, then SW addr=0x0000_0010, wdata=0xDEADBEEF -> ISSUE cycle shows mem_we=1, mem_addr=0x4, sel=1111, wdata=0xDEADBEEF; resp_valid at T+2 with fault=0 and rdata=0.
- SB addr=0x13, wdata=0x000000A5 -> sel=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x4. Then SH addr=0x12, wdata=0x1234 -> sel=1100, mem_wdata=0x12341234.
- Load with mem_rdata model returning 0x80FF7F01, addr byte offset 3:
  - LB -> 0xFFFFFF80; LBU -> 0x00000080.
  - LH at offset 2 -> 0xFFFF80FF; LHU -> 0x000080FF.
  - LW at offset 0 -> 0x80FF7F01.
  - All at T+3.
- Faults -> resp_fault=1 at T+1, rdata=0, mem_we never high:
  - LW addr=0x2.
  - SH addr=0x1.
  - op=011.
  - Store with op=100.
- resp_ready held low for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0 throughout, no mem_we. On release, req_ready=1 on the next cycle.
- rst_n asserted during the ISSUE cycle of an SW -> mem_we low at once and no write seen by the memory model. After release: resp_valid=0, req_ready=1.
